bytestuffer_stream: RTL and testbench

- Parametrised successor to the JPEG entropy-coder byte stuffer. Sits between the Huffman bit packer and the output byte sink.
- Buffers incoming bytes in an internal FIFO and inserts 0x00 after every stuffable 0xFF.
- New over the previous generation:
  - configurable FIFO depth;
  - output ready/valid backpressure;
  - a per-byte raw flag, so marker bytes (FFD0-FFD7, FFD9) pass unstuffed;
  - fill-level and input-ready reporting.
- Overflow detection is retained.

---
 rtl/bytestuffer_stream_pkg.sv | 22 ++
 rtl/bytestuffer_stream_sync_fifo_fwft.sv | 54 +++++
 rtl/bytestuffer_stream.sv | 107 ++++++++++
 tb/tb_bytestuffer_stream.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bytestuffer_stream_pkg.sv
// rtl/bytestuffer_stream_pkg.sv - shared constants, FIFO entry type and FSM states for the byte stuffer
package bytestuffer_stream_pkg;

  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] DEFAULT_STUFF_BYTE = 8'h00;

  typedef struct packed {
    logic       raw;
    logic [7:0] data;
  } fifo_entry_t;

  typedef enum logic {
    ST_EMIT  = 1'b0,
    ST_STUFF = 1'b1
  } stuff_state_t;

  // Marker bytes travel with raw=1 so they are never followed by a stuff byte.
  function automatic logic is_stuffable(input fifo_entry_t e);
    return (!e.raw) && (e.data == JPEG_MARKER_PREFIX);
  endfunction

endpackage

// File: rtl/bytestuffer_stream_sync_fifo_fwft.sv
// rtl/bytestuffer_stream_sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO with fill level
module sync_fifo_fwft #(
  parameter int WIDTH      = 9,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_wr_en,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  output logic [WIDTH-1:0]      o_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_fill_level
);

  logic [WIDTH-1:0]    r_mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_wr_fire;
  logic                w_rd_fire;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign o_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                   (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_fill_level = r_wr_ptr - r_rd_ptr;

  assign w_wr_fire = i_wr_en && !o_full;
  assign w_rd_fire = i_rd_en && !o_empty;

  always_ff @(posedge clock) begin
    if (w_wr_fire) begin
      r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_fire) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bytestuffer_stream.sv
// rtl/bytestuffer_stream.sv - buffered JPEG byte stuffer with raw marker bypass and output backpressure
module bytestuffer_stream
  import bytestuffer_stream_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 10,
  parameter logic [7:0] STUFF_BYTE = DEFAULT_STUFF_BYTE
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                data_in_valid,
  input  logic [7:0]          data_in,
  input  logic                data_in_raw,
  output logic                in_ready,
  output logic                data_out_valid,
  input  logic                data_out_ready,
  output logic [7:0]          data_out,
  output logic [DEPTH_LOG2:0] fill_level,
  output logic                overflow
);

  stuff_state_t r_state;
  stuff_state_t w_state_next;
  logic [7:0]   r_data;
  logic [7:0]   w_data_next;
  logic         r_valid;
  logic         w_valid_next;
  logic         r_overflow;
  logic         w_pop;
  logic         w_full;
  logic         w_empty;
  logic         w_out_free;
  fifo_entry_t  w_wr_entry;
  fifo_entry_t  w_head;

  assign w_wr_entry = '{raw: data_in_raw, data: data_in};

  sync_fifo_fwft #(
    .WIDTH      ($bits(fifo_entry_t)),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .i_wr_en      (data_in_valid),
    .i_wr_data    (w_wr_entry),
    .i_rd_en      (w_pop),
    .o_rd_data    (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_fill_level (fill_level)
  );

  assign w_out_free = !r_valid || data_out_ready;

  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_data;
    w_valid_next = r_valid;
    w_pop        = 1'b0;
    case (r_state)
      ST_EMIT: begin
        if (w_out_free) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_data_next  = w_head.data;
            w_valid_next = 1'b1;
            if (is_stuffable(w_head)) begin
              w_state_next = ST_STUFF;
            end
          end else begin
            w_valid_next = 1'b0;
          end
        end
      end
      ST_STUFF: begin
        // The stuff byte is generated locally, so FIFO occupancy does not matter here.
        if (w_out_free) begin
          w_data_next  = STUFF_BYTE;
          w_valid_next = 1'b1;
          w_state_next = ST_EMIT;
        end
      end
      default: begin
        w_state_next = ST_EMIT;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_EMIT;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_data     <= w_data_next;
      r_valid    <= w_valid_next;
      r_overflow <= r_overflow || (data_in_valid && w_full);
    end
  end

  assign in_ready       = !w_full;
  assign data_out_valid = r_valid;
  assign data_out       = r_data;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_bytestuffer_stream.sv
// tb/tb_bytestuffer_stream.sv - self-checking bench for bytestuffer_stream
module tb_bytestuffer_stream;

  localparam int DL2   = 10;
  localparam int DEPTH = 1 << DL2;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         data_in_valid = 1'b0;
  logic [7:0]   data_in = 8'h00;
  logic         data_in_raw = 1'b0;
  logic         data_out_ready = 1'b0;
  logic         in_ready;
  logic         data_out_valid;
  logic [7:0]   data_out;
  logic [DL2:0] fill_level;
  logic         overflow;

  bytestuffer_stream #(.DEPTH_LOG2(DL2), .STUFF_BYTE(8'h00)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .data_in_raw    (data_in_raw),
    .in_ready       (in_ready),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out       (data_out),
    .fill_level     (fill_level),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  bit         mon_en = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clock) begin
    if (mon_en) begin
      if (prev_stall) begin
        check("hold_valid", 32'(data_out_valid), 32'(1));
        check("hold_data", 32'(data_out), 32'(prev_data));
      end
      if (data_out_valid && data_out_ready) got_q.push_back(data_out);
      prev_stall = data_out_valid && !data_out_ready;
      prev_data  = data_out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    data_in_valid = v;
    data_in       = d;
    data_in_raw   = r;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic compare_stream(input string name);
    check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check(name, 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  typedef struct {
    logic       vin;
    logic [7:0] din;
    logic       raw;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_fill;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic       v;
    logic       r;
    logic [7:0] d;

    vecs[0]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    vecs[1]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1};
    vecs[2]  = '{1'b1, 8'hD9, 1'b1, 1'b1, 1'b1, 8'h00, 2};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hD9, 0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hD9, 0};
    vecs[6]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 8'hD9, 1};
    vecs[7]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h12, 1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h12, 1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 0};
    vecs[11] = '{1'b1, 8'h34, 1'b1, 1'b1, 1'b1, 8'h00, 1};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h34, 0};
    vecs[13] = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 8'h34, 1};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A, 0};

    do_reset();
    check("rst_valid", 32'(data_out_valid), 32'(0));
    check("rst_data", 32'(data_out), 32'(0));
    check("rst_fill", 32'(fill_level), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));

    // Cycle-exact table: marker pass-through, backpressure hold, raw non-FF byte.
    for (int i = 0; i < 16; i++) begin
      data_out_ready = vecs[i].rdy;
      drive(vecs[i].vin, vecs[i].din, vecs[i].raw);
      check($sformatf("vec%0d_valid", i), 32'(data_out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_fill", i), 32'(fill_level), 32'(vecs[i].exp_fill));
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(1));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(0));
    end

    // Random stream with 50% backpressure against a stuffing scoreboard.
    do_reset();
    got_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      r = ($urandom_range(0, 3) == 0);
      data_out_ready = 1'($urandom_range(0, 1));
      if (v) begin
        exp_q.push_back(d);
        if (d == 8'hFF && !r) exp_q.push_back(8'h00);
      end
      drive(v, d, r);
    end
    data_out_ready = 1'b1;
    repeat (60) drive(1'b0, 8'h00, 1'b0);
    mon_en = 1'b0;
    compare_stream("rand_stream");
    check("rand_overflow", 32'(overflow), 32'(0));
    check("rand_fill", 32'(fill_level), 32'(0));

    // Drain before full: 1016 stuffable FFs, then idle.
    do_reset();
    got_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    data_out_ready = 1'b1;
    for (int i = 0; i < 1016; i++) begin
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      drive(1'b1, 8'hFF, 1'b0);
    end
    repeat (1200) drive(1'b0, 8'h00, 1'b0);
    mon_en = 1'b0;
    compare_stream("drain_stream");
    check("drain_overflow", 32'(overflow), 32'(0));
    check("drain_fill", 32'(fill_level), 32'(0));

    // Overflow boundary: FIFO gains one entry per two cycles until full.
    do_reset();
    data_out_ready = 1'b1;
    for (int n = 0; n <= 2 * DEPTH - 2; n++) begin
      drive(1'b1, 8'hFF, 1'b0);
      check("ovf_ramp_fill", 32'(fill_level), 32'(n / 2 + 1));
      check("ovf_ramp_flag", 32'(overflow), 32'(0));
      check("ovf_ramp_in_ready", 32'(in_ready), 32'((n / 2 + 1) != DEPTH));
    end
    drive(1'b1, 8'hFF, 1'b0);
    check("ovf_first_drop_flag", 32'(overflow), 32'(1));
    check("ovf_first_drop_fill", 32'(fill_level), 32'(DEPTH - 1));
    repeat (20) drive(1'b1, 8'hFF, 1'b0);
    data_in_valid = 1'b0;
    repeat (20) drive(1'b0, 8'h00, 1'b0);
    check("ovf_sticky", 32'(overflow), 32'(1));
    do_reset();
    check("ovf_cleared", 32'(overflow), 32'(0));

    // Reset while in STUFF with 5 bytes buffered.
    data_out_ready = 1'b0;
    drive(1'b1, 8'hFF, 1'b0);
    drive(1'b1, 8'h01, 1'b0);
    drive(1'b1, 8'h02, 1'b0);
    drive(1'b1, 8'h03, 1'b0);
    drive(1'b1, 8'h04, 1'b0);
    drive(1'b1, 8'h05, 1'b0);
    check("pre_rst_valid", 32'(data_out_valid), 32'(1));
    check("pre_rst_data", 32'(data_out), 32'(8'hFF));
    check("pre_rst_fill", 32'(fill_level), 32'(5));
    data_in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(data_out_valid), 32'(0));
    check("mid_rst_fill", 32'(fill_level), 32'(0));
    @(posedge clock);
    #1;
    check("mid_rst_valid_next", 32'(data_out_valid), 32'(0));
    check("mid_rst_fill_next", 32'(fill_level), 32'(0));
    check("mid_rst_overflow", 32'(overflow), 32'(0));
    reset = 1'b0;
    data_out_ready = 1'b1;
    got_q.delete();
    mon_en = 1'b1;
    repeat (10) drive(1'b0, 8'h00, 1'b0);
    mon_en = 1'b0;
    check("post_rst_no_output", 32'(got_q.size()), 32'(0));
    check("post_rst_valid", 32'(data_out_valid), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
